// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package wb_pkg;

  localparam int WB_RWIDTH = 6;
  localparam int WB_DWIDTH = 32;

  typedef struct packed {
    logic                 live;
    logic [WB_RWIDTH-1:0] wa;
    logic [WB_DWIDTH-1:0] wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// In-order load result buffer with parallel address-compare kill; head is read combinationally.
// Push/pop take effect on the next edge; the caller must not push when full or pop when empty.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int RWIDTH = WB_RWIDTH,
  parameter int DWIDTH = WB_DWIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       push_live_i,
  input  logic [RWIDTH-1:0]          push_wa_i,
  input  logic [DWIDTH-1:0]          push_wd_i,
  input  logic                       pop_i,
  input  logic                       kill_i,
  input  logic [RWIDTH-1:0]          kill_wa_i,
  output logic                       head_live_o,
  output logic [RWIDTH-1:0]          head_wa_o,
  output logic [DWIDTH-1:0]          head_wd_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  live_q;
  logic [RWIDTH-1:0] wa_q [DEPTH];
  logic [DWIDTH-1:0] wd_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  assign head_live_o = live_q[rd_ptr_q];
  assign head_wa_o   = wa_q[rd_ptr_q];
  assign head_wd_o   = wd_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      wa_q[wr_ptr_q] <= push_wa_i;
      wd_q[wr_ptr_q] <= push_wd_i;
    end
  end

  // Kill may touch unoccupied slots harmlessly; a same-cycle push overrides its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && (wa_q[i] == kill_wa_i)) live_q[i] <= 1'b0;
      end
      if (push_i) begin
        live_q[wr_ptr_q] <= push_live_i;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU > buffered load > bypassed load, 1-cycle registered rf_we/wa/wd, WAW kill.
// ld_ready low while buffer full or in reset; WB_SCOREBOARD_EN adds the registered pend_mask output.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int RWIDTH = WB_RWIDTH,
  parameter int DWIDTH = WB_DWIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [RWIDTH-1:0]      alu_wa,
  input  logic [DWIDTH-1:0]      alu_wd,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [RWIDTH-1:0]      ld_wa,
  input  logic [DWIDTH-1:0]      ld_wd,
  output logic                   rf_we,
  output logic [RWIDTH-1:0]      rf_wa,
  output logic [DWIDTH-1:0]      rf_wd,
  output logic [$clog2(DEPTH):0] buf_count
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [2**RWIDTH-1:0]   pend_mask
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic              head_live;
  logic [RWIDTH-1:0] head_wa;
  logic [DWIDTH-1:0] head_wd;
  logic              ld_hs, kill, push, push_live, pop;
  wb_src_e           src;

  logic              rf_we_q, rf_we_d;
  logic [RWIDTH-1:0] rf_wa_q, rf_wa_d;
  logic [DWIDTH-1:0] rf_wd_q, rf_wd_d;

  assign ld_ready  = rst_n && (buf_count < FULL);
  assign ld_hs     = ld_valid && ld_ready;
  assign kill      = alu_valid && (alu_wa != '0);
  // A load colliding with a same-cycle ALU write is the older value, so it is born dead.
  assign push_live = (ld_wa != '0) && !(kill && (alu_wa == ld_wa));

  always_comb begin
    src = SRC_NONE;
    if (alu_valid)              src = SRC_ALU;
    else if (buf_count != '0)   src = SRC_BUF;
    else if (ld_hs)             src = SRC_BYP;
  end

  assign pop  = (src == SRC_BUF);
  assign push = ld_hs && (src != SRC_BYP);

  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    case (src)
      SRC_ALU: begin
        rf_we_d = (alu_wa != '0);
        rf_wa_d = alu_wa;
        rf_wd_d = alu_wd;
      end
      SRC_BUF: begin
        rf_we_d = head_live && (head_wa != '0);
        rf_wa_d = head_wa;
        rf_wd_d = head_wd;
      end
      SRC_BYP: begin
        rf_we_d = (ld_wa != '0);
        rf_wa_d = ld_wa;
        rf_wd_d = ld_wd;
      end
      default: rf_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  wb_load_fifo #(
    .RWIDTH (RWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_live_i (push_live),
    .push_wa_i   (ld_wa),
    .push_wd_i   (ld_wd),
    .pop_i       (pop),
    .kill_i      (kill),
    .kill_wa_i   (alu_wa),
    .head_live_o (head_live),
    .head_wa_o   (head_wa),
    .head_wd_o   (head_wd),
    .count_o     (buf_count)
  );

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 2**RWIDTH;

  logic [CW-1:0]   pend_cnt_q [NREG];
  logic [CW-1:0]   pend_cnt_d [NREG];
  logic [NREG-1:0] pend_mask_q, pend_mask_d;

  // Pop and kill are mutually exclusive (kill needs the ALU, pop needs it idle), and a kill
  // removes every live entry for that register, so its counter simply returns to zero.
  always_comb begin
    pend_mask_d = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_cnt_d[r] = pend_cnt_q[r];
      if (r != 0) begin
        if (kill && (alu_wa == RWIDTH'(r))) begin
          pend_cnt_d[r] = '0;
        end else begin
          if (push && push_live && (ld_wa == RWIDTH'(r)))
            pend_cnt_d[r] = pend_cnt_d[r] + CW'(1);
          if (pop && head_live && (head_wa == RWIDTH'(r)))
            pend_cnt_d[r] = pend_cnt_d[r] - CW'(1);
        end
      end
      pend_mask_d[r] = (pend_cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_cnt_q[r] <= '0;
      pend_mask_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_cnt_q[r] <= pend_cnt_d[r];
      pend_mask_q <= pend_mask_d;
    end
  end

  assign pend_mask = pend_mask_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a cycle model predicts every rf write, buf_count and ld_ready.
// Checks pend_mask as well when WB_SCOREBOARD_EN is defined.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int RW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NREG  = 2**RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [RW-1:0] alu_wa = '0;
  logic [DW-1:0] alu_wd = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [RW-1:0] ld_wa = '0;
  logic [DW-1:0] ld_wd = '0;
  logic          rf_we;
  logic [RW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [CW-1:0] buf_count;
`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] pend_mask;
`endif

  wb_arbiter #(.RWIDTH(RW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_wa     (ld_wa),
    .ld_wd     (ld_wd),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .buf_count (buf_count)
`ifdef WB_SCOREBOARD_EN
    ,
    .pend_mask (pend_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  wb_entry_t       mb[$];
  wb_entry_t       exp_q[$];
  int              cnt_q[$];
  logic [NREG-1:0] mask_q[$];
  logic            model_hs;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] model_mask();
    logic [NREG-1:0] m = '0;
    foreach (mb[i]) if (mb[i].live) m[mb[i].wa] = 1'b1;
    return m;
  endfunction

  task automatic compare_outputs();
    wb_entry_t       e;
    int              c;
    logic [NREG-1:0] m;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      m = mask_q.pop_front();
      check_eq("rf_we", rf_we, e.live);
      if (e.live) begin
        check_eq("rf_wa", rf_wa, e.wa);
        check_eq("rf_wd", rf_wd, e.wd);
      end
      check_eq("buf_count", buf_count, c);
`ifdef WB_SCOREBOARD_EN
      check_eq("pend_mask", pend_mask, m);
`endif
    end
  endtask

  // One clock of stimulus; the model's prediction for the next edge goes to the scoreboard.
  task automatic cycle(input logic av, input logic [RW-1:0] awa, input logic [DW-1:0] awd,
                       input logic lv, input logic [RW-1:0] lwa, input logic [DW-1:0] lwd);
    wb_entry_t e;
    logic      rdy, byp;
    @(negedge clk);
    compare_outputs();
    alu_valid = av; alu_wa = awa; alu_wd = awd;
    ld_valid  = lv; ld_wa  = lwa; ld_wd  = lwd;
    rdy = (mb.size() < DEPTH);
    check_eq("ld_ready", ld_ready, rdy);
    model_hs = lv && rdy;
    byp = 1'b0;
    e = '0;
    if (av) begin
      e = '{live: (awa != 0), wa: awa, wd: awd};
      if (awa != 0) foreach (mb[i]) if (mb[i].wa == awa) mb[i].live = 1'b0;
    end else if (mb.size() != 0) begin
      e = mb.pop_front();
    end else if (model_hs) begin
      e = '{live: (lwa != 0), wa: lwa, wd: lwd};
      byp = 1'b1;
    end
    if (model_hs && !byp)
      mb.push_back('{live: (lwa != 0) && !(av && awa == lwa), wa: lwa, wd: lwd});
    exp_q.push_back(e);
    cnt_q.push_back(mb.size());
    mask_q.push_back(model_mask());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    int k;
    logic [RW-1:0] rwa;
    logic [DW-1:0] rwd;

    #12;
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_rf_wa", rf_wa, '0);
    check_eq("rst_rf_wd", rf_wd, '0);
    check_eq("rst_buf_count", buf_count, '0);
    check_eq("rst_ld_ready", ld_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass
    cycle(1'b0, '0, '0, 1'b1, 6'd5, 32'hDEADBEEF);
    idle(1);

    // ALU priority over a simultaneous load
    cycle(1'b1, 6'd3, 32'h11, 1'b1, 6'd7, 32'h22);
    idle(2);

    // Fill under ALU pressure, then drain in order
    k = 0;
    for (int c = 0; c < 9; c++) begin
      cycle(c < 6, RW'(10 + c), DW'(32'h100 + c), k < 5, RW'(20 + k), DW'(32'h200 + k));
      if (model_hs) k++;
    end
    idle(6);

    // WAW kill
    cycle(1'b1, 6'd1, 32'h1, 1'b1, 6'd9, 32'hAAAA);
    cycle(1'b1, 6'd9, 32'hBBBB, 1'b0, '0, '0);
    idle(3);

    // Same-cycle collision, r0 loads (bypassed and buffered), ALU to r0
    cycle(1'b1, 6'd4, 32'h1, 1'b1, 6'd4, 32'h2);
    idle(2);
    cycle(1'b0, '0, '0, 1'b1, 6'd0, 32'h55);
    cycle(1'b1, 6'd2, 32'h3, 1'b1, 6'd0, 32'h66);
    cycle(1'b1, 6'd0, 32'h77, 1'b0, '0, '0);
    idle(3);

    // Random traffic on a few registers to provoke kills and collisions
    rwa = RW'($urandom_range(0, 3));
    rwd = $urandom;
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 2) == 0, RW'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) == 1, rwa, rwd);
      if (model_hs) begin
        rwa = RW'($urandom_range(0, 3));
        rwd = $urandom;
      end
    end
    idle(6);

    // Asynchronous reset with three buffered loads
    cycle(1'b1, 6'd1, 32'h10, 1'b1, 6'd11, 32'h1011);
    cycle(1'b1, 6'd2, 32'h20, 1'b1, 6'd12, 32'h1012);
    cycle(1'b1, 6'd3, 32'h30, 1'b1, 6'd13, 32'h1013);
    @(negedge clk);
    compare_outputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rf_we", rf_we, 1'b0);
    check_eq("arst_buf_count", buf_count, '0);
    check_eq("arst_ld_ready", ld_ready, 1'b0);
`ifdef WB_SCOREBOARD_EN
    check_eq("arst_pend_mask", pend_mask, '0);
`endif
    mb.delete();
    exp_q.delete();
    cnt_q.delete();
    mask_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    @(negedge clk);
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
